// File: rtl/note2cnt.sv
`default_nettype none
// ============================================================================
//  Module   : note2cnt
//  Purpose  : Converts a MIDI note number into the half-period count used by a
//             downstream square-wave generator running on a 1 MHz tick. The
//             note is split into octave (shift) and semitone (note index). The
//             semitone selects a lowest-octave count, which is then
//             right-shifted by the octave. The result is registered, so there
//             is exactly one clock of latency.
//  Ports    : clk_i            - system clock
//             nrst_i           - asynchronous active-low reset
//             note_i[7:0]      - MIDI note; bit 7 set means silence
//             halfCntPeriod_o  - half-period count in 1 MHz ticks; 0 = silence
//  Revision : 1.0 - initial release
// ============================================================================
module note2cnt #(
    parameter int BW = 16
) (
    input  logic          clk_i,
    input  logic          nrst_i,
    input  logic [7:0]    note_i,
    output logic [BW-1:0] halfCntPeriod_o
);

    logic [6:0]    w_note;
    logic [3:0]    w_shift;
    logic [6:0]    w_octave_base;
    logic [3:0]    w_note_index;
    logic [15:0]   w_base_cnt;
    logic [15:0]   w_shifted;
    logic [BW-1:0] w_result;
    logic [BW-1:0] r_half_cnt;

    assign w_note = note_i[6:0];

    // Divide by 12 using a threshold compare chain. The octave is the number
    // of multiples of 12 that do not exceed the note.
    always_comb begin
        w_shift = 4'd0;
        for (int k = 1; k <= 10; k++) begin
            if (w_note >= 7'(12 * k)) begin
                w_shift = 4'(k);
            end
        end
    end

    // 12 * shift is at most 120, so it fits in 7 bits.
    assign w_octave_base = {3'b000, w_shift} * 7'd12;
    assign w_note_index  = 4'(w_note - w_octave_base);

    // Lowest-octave half-period counts, round(500000 / f) for MIDI notes 0..11.
    always_comb begin
        case (w_note_index)
            4'd0:    w_base_cnt = 16'd61156;
            4'd1:    w_base_cnt = 16'd57724;
            4'd2:    w_base_cnt = 16'd54484;
            4'd3:    w_base_cnt = 16'd51426;
            4'd4:    w_base_cnt = 16'd48540;
            4'd5:    w_base_cnt = 16'd45815;
            4'd6:    w_base_cnt = 16'd43244;
            4'd7:    w_base_cnt = 16'd40817;
            4'd8:    w_base_cnt = 16'd38526;
            4'd9:    w_base_cnt = 16'd36364;
            4'd10:   w_base_cnt = 16'd34323;
            4'd11:   w_base_cnt = 16'd32396;
            default: w_base_cnt = 16'd0;
        endcase
    end

    // Each octave up halves the period. The logical shift truncates.
    assign w_shifted = w_base_cnt >> w_shift;

    // Zero-extend the 16-bit table result to the output width.
    always_comb begin
        w_result        = '0;
        w_result[15:0]  = w_shifted;
    end

    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            r_half_cnt <= '0;
        end else if (note_i[7]) begin
            r_half_cnt <= '0;
        end else begin
            r_half_cnt <= w_result;
        end
    end

    assign halfCntPeriod_o = r_half_cnt;

endmodule
`default_nettype wire

// File: tb/tb_note2cnt.sv
`default_nettype none
// ============================================================================
//  Module   : tb_note2cnt
//  Purpose  : Self-checking bench for note2cnt. A reference model computes
//             the equal-tempered count from the note using division and
//             modulo. A compare process checks the DUT against that model on
//             every falling edge. Directed checks pin the model to
//             hand-computed literal values.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_note2cnt;

    localparam int BW = 16;

    logic          clk_i;
    logic          nrst_i;
    logic [7:0]    note_i;
    logic [BW-1:0] halfCntPeriod_o;

    int checks = 0;
    int errors = 0;

    logic          armed = 1'b0;
    logic [BW-1:0] exp_q = '0;

    note2cnt #(.BW(BW)) dut (
        .clk_i           (clk_i),
        .nrst_i          (nrst_i),
        .note_i          (note_i),
        .halfCntPeriod_o (halfCntPeriod_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Reference: lowest-octave count divided by 2^(note/12).
    function automatic int model(input logic [7:0] n);
        int tbl [12];
        int v;
        tbl = '{61156, 57724, 54484, 51426, 48540, 45815,
                43244, 40817, 38526, 36364, 34323, 32396};
        if (n[7]) return 0;
        v = int'(n);
        return tbl[v % 12] / (1 << (v / 12));
    endfunction

    // The expected output follows the documented timing: reset clears it at
    // once, and otherwise it takes the model value of the note sampled at the
    // rising edge.
    always @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) exp_q = '0;
        else         exp_q = BW'(model(note_i));
    end

    always @(negedge clk_i) begin
        if (armed) begin
            checks++;
            if (halfCntPeriod_o !== exp_q) begin
                errors++;
                $display("FAIL cycle_compare note=%0d actual=%0d expected=%0d",
                         note_i, halfCntPeriod_o, exp_q);
            end
        end
    end

    task automatic check(input string name, input logic [BW-1:0] exp);
        checks++;
        if (halfCntPeriod_o !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, halfCntPeriod_o, exp);
        end
    endtask

    // Drive a note at the falling edge, then sample just after the next
    // rising edge.
    task automatic apply(input logic [7:0] n);
        @(negedge clk_i);
        note_i = n;
        @(posedge clk_i);
        #1;
    endtask

    typedef struct { logic [7:0] note; int exp; string name; } vec_t;

    initial begin
        vec_t vecs [12];
        logic [BW-1:0] prev;

        vecs = '{
            '{8'd69,  1136,  "ref_69"},
            '{8'd60,  1911,  "ref_60"},
            '{8'd72,  955,   "ref_72"},
            '{8'd57,  2272,  "ref_57"},
            '{8'd0,   61156, "note_0"},
            '{8'd11,  32396, "note_11"},
            '{8'd12,  30578, "note_12"},
            '{8'd127, 39,    "note_127"},
            '{8'd128, 0,     "inv_128"},
            '{8'd200, 0,     "inv_200"},
            '{8'd255, 0,     "inv_255"},
            '{8'd64,  1516,  "note_64"}
        };

        nrst_i = 1'b0;
        note_i = 8'd69;
        repeat (3) @(posedge clk_i);
        #1;
        armed = 1'b1;
        check("reset_hold", '0);

        @(negedge clk_i);
        nrst_i = 1'b1;
        @(posedge clk_i);
        #1;
        check("reset_release", 16'd1136);

        foreach (vecs[i]) begin
            apply(vecs[i].note);
            check(vecs[i].name, BW'(vecs[i].exp));
        end

        // Sweep all valid notes. The output must match the model and must
        // never increase.
        prev = 16'hFFFF;
        for (int n = 0; n < 128; n++) begin
            apply(8'(n));
            check("sweep", BW'(model(8'(n))));
            checks++;
            if (halfCntPeriod_o > prev) begin
                errors++;
                $display("FAIL monotonic note=%0d actual=%0d previous=%0d",
                         n, halfCntPeriod_o, prev);
            end
            prev = halfCntPeriod_o;
        end

        // An asynchronous reset in the middle of a cycle must clear the
        // output without waiting for a clock edge.
        apply(8'd48);
        check("pre_async", 16'd3822);
        #2;
        nrst_i = 1'b0;
        #1;
        check("async_clear", '0);
        #1;
        nrst_i = 1'b1;
        @(posedge clk_i);
        #1;
        check("async_release", 16'd3822);

        repeat (2) @(negedge clk_i);
        armed = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
